// File: rtl/io_row_loader.sv
// Input-side IO packing controller: accepts SECTION_W-bit sections over valid/ready,
// packs them LSB-first into ROW_W-bit rows and writes each row to consecutive addresses.
module io_row_loader #(
  parameter int SECTION_W = 4,
  parameter int ROW_W     = 16,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     total_sections,
  input  logic                 abort,
  input  logic [SECTION_W-1:0] in_section,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_wr_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [ROW_W-1:0]     mem_wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int SPR    = ROW_W / SECTION_W;
  localparam int SLOT_W = (SPR > 1) ? $clog2(SPR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [SLOT_W-1:0]   r_slot;
  logic [CNT_W-1:0]    r_remaining;
  logic [ADDR_W-1:0]   r_addr, r_mem_addr;
  logic [ROW_W-1:0]    r_acc, r_mem_wr_data, w_row;
  logic                r_mem_wr_en;
  logic                w_start_load, w_start_zero, w_beat, w_last, w_row_done;

  always_comb begin
    w_start_load = (r_state == S_IDLE) && start && (total_sections != '0);
    w_start_zero = (r_state == S_IDLE) && start && (total_sections == '0);
    // abort wins over a beat presented in the same cycle
    w_beat       = (r_state == S_LOAD) && in_valid && !abort;
    w_last       = (r_remaining == CNT_W'(1));
    w_row_done   = w_beat && (w_last || (r_slot == SLOT_W'(SPR - 1)));
    w_row        = r_acc;
    w_row[int'(r_slot) * SECTION_W +: SECTION_W] = in_section;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_load)      w_state_next = S_LOAD;
        else if (w_start_zero) w_state_next = S_DONE;
      end
      S_LOAD: begin
        if (abort)                w_state_next = S_IDLE;
        else if (w_beat && w_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot        <= '0;
      r_remaining   <= '0;
      r_addr        <= '0;
      r_acc         <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      r_mem_wr_en <= 1'b0;
      if (w_start_load) begin
        r_addr      <= base_addr;
        r_remaining <= total_sections;
        r_slot      <= '0;
        r_acc       <= '0;
      end else if (r_state == S_LOAD) begin
        if (abort) begin
          r_slot <= '0;
          r_acc  <= '0;
        end else if (w_beat) begin
          r_remaining <= r_remaining - 1'b1;
          if (w_row_done) begin
            r_mem_wr_en   <= 1'b1;
            r_mem_addr    <= r_addr;
            r_mem_wr_data <= w_row;
            r_addr        <= r_addr + 1'b1;
            r_slot        <= '0;
            r_acc         <= '0;
          end else begin
            r_acc  <= w_row;
            r_slot <= r_slot + 1'b1;
          end
        end
      end
    end
  end

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_io_row_loader.sv
// Scoreboard bench for io_row_loader: stimulus pushes hand-computed row writes and done
// pulses (with their expected cycle); a negedge monitor pops and compares them.
module tb_io_row_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [11:0] total_sections = '0;
  logic        abort = 1'b0;
  logic [3:0]  in_section = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_wr_en, busy, done;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wr_data;

  io_row_loader #(.SECTION_W(4), .ROW_W(16), .ADDR_W(10), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .total_sections(total_sections), .abort(abort), .in_section(in_section),
    .in_valid(in_valid), .in_ready(in_ready), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { bit with_wr; int cyc; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t exp_rows[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write / done is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        if (wq.size() == 0) chk("unexpected_write", 32'(mem_wr_en), 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", 32'(mem_wr_data), 32'(w.data));
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          dn_t d;
          d = dq.pop_front();
          chk("done_with_write", 32'(mem_wr_en), 32'(d.with_wr));
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
        end
      end
    end
  end

  task automatic add_row(input logic [9:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d; w.cyc = 0;
    exp_rows.push_back(w);
  endtask

  task automatic do_start(input logic [9:0] b, input logic [11:0] n);
    start = 1'b1; base_addr = b; total_sections = n;
    if (n == 0) begin
      dn_t d;
      d.with_wr = 1'b0; d.cyc = cyc + 1;
      dq.push_back(d);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_in_ready", 32'(in_ready), (n != 0) ? 32'd1 : 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Sends sections first, first+1, ... ; a beat completes a row when it fills slot 3
  // or is the transfer's final section.
  task automatic send(input logic [3:0] first, input int cnt, input int total,
                      input bit gap, input bit inject);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      in_section = first + 4'(i);
      if ((i % 4 == 3) || (i == total - 1)) begin
        wr_t w;
        w = exp_rows.pop_front();
        w.cyc = cyc + 1;
        wq.push_back(w);
      end
      if (i == total - 1) begin
        dn_t d;
        d.with_wr = 1'b1; d.cyc = cyc + 1;
        dq.push_back(d);
      end
      @(posedge clk); #1;
      if (gap && i != cnt - 1) begin
        in_valid = 1'b0;
        if (inject && i == 2) begin
          start = 1'b1; base_addr = 10'h200; total_sections = 12'd2;
        end
        @(negedge clk);
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic end_check();
    @(posedge clk); #1;
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_writes_pending"}, 32'(wq.size()), 32'd0);
    chk({tag, "_done_pending"}, 32'(dq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 8 sections back-to-back
    add_row(10'h010, 16'h4321); add_row(10'h011, 16'h8765);
    do_start(10'h010, 12'd8);
    send(4'd1, 8, 8, 1'b0, 1'b0);
    end_check();
    drain("full8");

    // 6 sections, last row zero-padded
    add_row(10'h020, 16'h4321); add_row(10'h021, 16'h0065);
    do_start(10'h020, 12'd6);
    send(4'd1, 6, 6, 1'b0, 1'b0);
    end_check();
    drain("part6");

    // valid gaps plus a start pulse while busy (must be ignored)
    add_row(10'h030, 16'h4321); add_row(10'h031, 16'h8765);
    do_start(10'h030, 12'd8);
    send(4'd1, 8, 8, 1'b1, 1'b1);
    end_check();
    drain("gaps");

    // zero-length command
    do_start(10'h040, 12'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_idle_busy", 32'(busy), 32'd0);
    chk("zero_in_ready", 32'(in_ready), 32'd0);
    drain("zero");

    // address wrap
    add_row(10'h3FF, 16'h4321); add_row(10'h000, 16'h8765);
    do_start(10'h3FF, 12'd8);
    send(4'd1, 8, 8, 1'b0, 1'b0);
    end_check();
    drain("wrap");

    // abort after 3 sections; the beat alongside abort is dropped
    do_start(10'h050, 12'd8);
    send(4'd1, 3, 8, 1'b0, 1'b0);
    in_valid = 1'b1; in_section = 4'd4; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    drain("abort");
    add_row(10'h060, 16'hCBA9);
    do_start(10'h060, 12'd4);
    send(4'd9, 4, 4, 1'b0, 1'b0);
    end_check();
    drain("post_abort");

    // asynchronous reset mid-transfer
    do_start(10'h070, 12'd8);
    send(4'd1, 3, 8, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    chk("arst_data", 32'(mem_wr_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    add_row(10'h080, 16'h0065);
    do_start(10'h080, 12'd2);
    send(4'd5, 2, 2, 1'b0, 1'b0);
    end_check();
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
